// File: rtl/rv_branch_pred_ctrl.sv
// Branch prediction controller: PC-indexed 2-bit counter table, registered
// mispredict flush/redirect, sequenced table-clear sweep and saturating stats.
module rv_branch_pred_ctrl #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             i_bpc_clk,
    input  logic             i_bpc_rstn,
    input  logic [31:0]      i_bpc_if_pc,
    output logic             o_bpc_if_pred_taken,
    input  logic             i_bpc_ex_valid,
    input  logic [31:0]      i_bpc_ex_pc,
    input  logic             i_bpc_ex_pred_taken,
    input  logic             i_bpc_ex_taken,
    input  logic [31:0]      i_bpc_ex_target,
    output logic             o_bpc_flush,
    output logic [31:0]      o_bpc_redirect_pc,
    input  logic             i_bpc_clr_req,
    output logic             o_bpc_clr_busy,
    output logic [CNT_W-1:0] o_bpc_branch_cnt,
    output logic [CNT_W-1:0] o_bpc_mispred_cnt
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t           state_q;
    logic [1:0]       table_q [DEPTH];
    logic [IDX_W-1:0] clr_ptr_q;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ex_cur;
    logic [1:0]       ex_nxt;
    logic             mispred;
    logic             unused_pc_bits;

    assign if_idx = i_bpc_if_pc[IDX_W+1:2];
    assign ex_idx = i_bpc_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_bpc_if_pc[31:IDX_W+2], i_bpc_if_pc[1:0]};

    // Lookup sees the registered table only, so same-cycle updates are not bypassed.
    assign o_bpc_if_pred_taken = (state_q == ST_IDLE) & table_q[if_idx][1];

    assign mispred = i_bpc_ex_valid & (i_bpc_ex_pred_taken != i_bpc_ex_taken);

    always_comb begin
        ex_cur = table_q[ex_idx];
        ex_nxt = ex_cur;
        if (i_bpc_ex_taken) begin
            if (ex_cur != 2'b11) ex_nxt = ex_cur + 2'd1;
        end else begin
            if (ex_cur != 2'b00) ex_nxt = ex_cur - 2'd1;
        end
    end

    always_ff @(posedge i_bpc_clk or negedge i_bpc_rstn) begin
        if (!i_bpc_rstn) begin
            state_q        <= ST_IDLE;
            clr_ptr_q      <= '0;
            o_bpc_clr_busy <= 1'b0;
            table_q        <= '{default: 2'b00};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_bpc_ex_valid) table_q[ex_idx] <= ex_nxt;
                    if (i_bpc_clr_req) begin
                        state_q        <= ST_CLEAR;
                        clr_ptr_q      <= '0;
                        o_bpc_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    table_q[clr_ptr_q] <= 2'b00;
                    clr_ptr_q          <= clr_ptr_q + IDX_W'(1);
                    if (clr_ptr_q == '1) begin
                        state_q        <= ST_IDLE;
                        o_bpc_clr_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    o_bpc_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Flush and statistics run regardless of sweep state.
    always_ff @(posedge i_bpc_clk or negedge i_bpc_rstn) begin
        if (!i_bpc_rstn) begin
            o_bpc_flush       <= 1'b0;
            o_bpc_redirect_pc <= '0;
            o_bpc_branch_cnt  <= '0;
            o_bpc_mispred_cnt <= '0;
        end else begin
            o_bpc_flush <= mispred;
            if (mispred) begin
                o_bpc_redirect_pc <= i_bpc_ex_taken ? i_bpc_ex_target
                                                    : i_bpc_ex_pc + 32'd4;
            end
            if (i_bpc_ex_valid && (o_bpc_branch_cnt != '1)) begin
                o_bpc_branch_cnt <= o_bpc_branch_cnt + CNT_W'(1);
            end
            if (mispred && (o_bpc_mispred_cnt != '1)) begin
                o_bpc_mispred_cnt <= o_bpc_mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_branch_pred_ctrl.sv
// Scoreboard bench for rv_branch_pred_ctrl: directed stimulus pushes expected
// per-cycle observations and flush events; a negedge monitor pops and compares.
module tb_rv_branch_pred_ctrl;

    localparam int IDX_W = 6;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_pred_taken;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             clr_req;
    logic             clr_busy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    rv_branch_pred_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .i_bpc_clk           (clk),
        .i_bpc_rstn          (rstn),
        .i_bpc_if_pc         (if_pc),
        .o_bpc_if_pred_taken (pred_taken),
        .i_bpc_ex_valid      (ex_valid),
        .i_bpc_ex_pc         (ex_pc),
        .i_bpc_ex_pred_taken (ex_pred_taken),
        .i_bpc_ex_taken      (ex_taken),
        .i_bpc_ex_target     (ex_target),
        .o_bpc_flush         (flush),
        .o_bpc_redirect_pc   (redirect_pc),
        .i_bpc_clr_req       (clr_req),
        .o_bpc_clr_busy      (clr_busy),
        .o_bpc_branch_cnt    (branch_cnt),
        .o_bpc_mispred_cnt   (mispred_cnt)
    );

    typedef struct {
        int          cyc;
        logic [31:0] redir;
    } fl_t;

    typedef struct {
        int         cyc;
        logic       pred;
        logic       busy;
        logic [3:0] bcnt;
        logic [3:0] mcnt;
    } obs_t;

    fl_t         fl_q[$];
    obs_t        obs_q[$];
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_br = 0;
    int          n_mp = 0;
    logic [31:0] last_redir = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, got, exp);
        end
    endtask

    function automatic logic [3:0] sat4(input int n);
        logic [31:0] v;
        v = n;
        return (n > 15) ? 4'd15 : v[3:0];
    endfunction

    // Monitor: flush/redirect checked every cycle, observations when queued.
    always @(negedge clk) begin
        logic exp_f;
        fl_t  f;
        obs_t o;
        exp_f = (fl_q.size() > 0) && (fl_q[0].cyc == cyc_n);
        chk("flush", {31'd0, flush}, {31'd0, exp_f});
        if (exp_f) begin
            f = fl_q.pop_front();
            last_redir = f.redir;
            chk("redirect", redirect_pc, f.redir);
        end else begin
            chk("redirect_hold", redirect_pc, last_redir);
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk("pred", {31'd0, pred_taken}, {31'd0, o.pred});
            chk("busy", {31'd0, clr_busy}, {31'd0, o.busy});
            chk("branch_cnt", {28'd0, branch_cnt}, {28'd0, o.bcnt});
            chk("mispred_cnt", {28'd0, mispred_cnt}, {28'd0, o.mcnt});
        end
    end

    task automatic step(input logic [31:0] ifpc, input logic exp_pred, input logic exp_busy,
                        input logic v, input logic [31:0] pc, input logic pt, input logic t,
                        input logic [31:0] tgt, input logic clr);
        obs_t o;
        fl_t  f;
        @(posedge clk);
        #1;
        if_pc         = ifpc;
        ex_valid      = v;
        ex_pc         = pc;
        ex_pred_taken = pt;
        ex_taken      = t;
        ex_target     = tgt;
        clr_req       = clr;
        o.cyc  = cyc_n;
        o.pred = exp_pred;
        o.busy = exp_busy;
        o.bcnt = sat4(n_br);
        o.mcnt = sat4(n_mp);
        obs_q.push_back(o);
        if (v) n_br++;
        if (v && (pt != t)) begin
            n_mp++;
            f.cyc   = cyc_n + 1;
            f.redir = t ? tgt : pc + 32'd4;
            fl_q.push_back(f);
        end
    endtask

    task automatic idle(input logic [31:0] ifpc, input logic exp_pred, input logic exp_busy);
        step(ifpc, exp_pred, exp_busy, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge.
    task automatic apply_reset();
        obs_t o;
        @(posedge clk);
        #1;
        rstn          = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
        clr_req       = 1'b0;
        fl_q.delete();
        n_br       = 0;
        n_mp       = 0;
        last_redir = '0;
        o.cyc  = cyc_n;
        o.pred = 1'b0;
        o.busy = 1'b0;
        o.bcnt = 4'd0;
        o.mcnt = 4'd0;
        obs_q.push_back(o);
        @(posedge clk);
        #3;
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
        clr_req       = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;

        // Training at 0x100 (index 0): 00 -> 01 -> 10 -> 11 -> 11
        idle(32'h100, 1'b0, 1'b0);
        step(32'h100, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b0);
        step(32'h100, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b0);
        step(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180, 1'b0);
        step(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180, 1'b0);
        idle(32'h100, 1'b1, 1'b0);

        // 0x200 aliases index 0: ST predicted taken, not taken -> WT, redirect 0x204
        step(32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 1'b0);
        idle(32'h200, 1'b1, 1'b0);
        // Same-cycle lookup via 0x100 returns old WT, update drops to WNT
        step(32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 1'b0);
        idle(32'h100, 1'b0, 1'b0);
        step(32'h140, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h180, 1'b0);
        idle(32'h100, 1'b0, 1'b0);

        // Train index 5 to ST, then clear sweep
        step(32'h14, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h40, 1'b0);
        step(32'h14, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h40, 1'b0);
        step(32'h14, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h40, 1'b0);
        step(32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            if (k == 13 || k == 14)
                step(32'h14, 1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 32'h44 + 32'(4 * (k - 13)), 1'b0);
            else if (k == 23)
                step(32'h14, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            else
                idle(32'h14, 1'b0, 1'b1);
        end
        idle(32'h14, 1'b0, 1'b0);
        idle(32'h14, 1'b0, 1'b0);

        // Counter saturation with CNT_W=4: 20 back-to-back mispredicts
        apply_reset();
        for (int i = 0; i < 20; i++)
            step(32'h300, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(32'h300, 1'b0, 1'b0);
        idle(32'h300, 1'b0, 1'b0);

        // Reset in the middle of a sweep aborts it
        step(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) idle(32'h300, 1'b0, 1'b1);
        apply_reset();
        idle(32'h300, 1'b0, 1'b0);
        idle(32'h300, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("flush_queue_empty", fl_q.size(), 32'd0);
        chk("obs_queue_empty", obs_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
